// File: rtl/keypad_bcd_entry_if.sv
// Keypad-side and counter-side signals of the keypad BCD entry block.
// The master modport is the entry block itself; the slave modport is the keypad/counter side.
interface keypad_bcd_entry_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        cfg;
    logic [15:0] tempo;
    logic        salve;
    logic        key_valid;
    logic [3:0]  key_code;

    modport master (
        input  row,
        input  cfg,
        output col,
        output tempo,
        output salve,
        output key_valid,
        output key_code
    );

    modport slave (
        output row,
        output cfg,
        input  col,
        input  tempo,
        input  salve,
        input  key_valid,
        input  key_code
    );
endinterface

// File: rtl/keypad_bcd_entry.sv
// 4x4 keypad scanner with snapshot debouncing and 4-digit decimal entry.
// Produces the binary value of the typed digits (0..9999) and a one-cycle '#' pulse.
module keypad_bcd_entry #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input logic                clk,
    input logic                reseta,
    keypad_bcd_entry_if.master kp
);

    localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned MATCH_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(DEBOUNCE_SCANS);

    // Keycode for snapshot bit index r*4+c.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    typedef enum logic [1:0] {StCol0, StCol1, StCol2, StCol3} scan_state_e;

    logic [3:0]         row_meta_q, row_sync_q;
    scan_state_e        state_q;
    logic [DIV_W-1:0]   div_q;
    logic [15:0]        work_q, work_merged, snap_q;
    logic               snap_valid_q;
    logic [3:0]         col_q;

    logic [15:0]        prev_q, stable_q;
    logic [MATCH_W-1:0] match_q, match_nx;
    logic               press_q;
    logic [3:0]         press_idx_q, snap_idx;

    logic [3:0]         code;
    logic [15:0]        digits_q;
    logic [15:0]        tempo_q, tempo_nx;
    logic               key_valid_q, salve_q;
    logic [3:0]         key_code_q;

    // Two-flop synchroniser for the asynchronous row inputs (reset = released).
    always_ff @(posedge clk or posedge reseta) begin
        if (reseta) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= kp.row;
            row_sync_q <= row_meta_q;
        end
    end

    // Fold the current column's pressed rows into the working snapshot.
    always_comb begin
        work_merged = work_q;
        for (int r = 0; r < 4; r++) begin
            work_merged[{2'(r), state_q}] = ~row_sync_q[2'(r)];
        end
    end

    // Column scan FSM: one column per SCAN_DIV cycles, snapshot completes on COL3 wrap.
    always_ff @(posedge clk or posedge reseta) begin
        if (reseta) begin
            state_q      <= StCol0;
            div_q        <= '0;
            work_q       <= '0;
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
            col_q        <= 4'b1110;
        end else begin
            snap_valid_q <= 1'b0;
            if (div_q == DIV_LAST) begin
                div_q  <= '0;
                work_q <= work_merged;
                unique case (state_q)
                    StCol0: begin state_q <= StCol1; col_q <= 4'b1101; end
                    StCol1: begin state_q <= StCol2; col_q <= 4'b1011; end
                    StCol2: begin state_q <= StCol3; col_q <= 4'b0111; end
                    StCol3: begin
                        state_q      <= StCol0;
                        col_q        <= 4'b1110;
                        snap_q       <= work_merged;
                        snap_valid_q <= 1'b1;
                    end
                endcase
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    // Match counter update and index of the (single) pressed key in the snapshot.
    always_comb begin
        if (snap_q == prev_q) begin
            match_nx = (match_q == MATCH_MAX) ? MATCH_MAX : match_q + 1'b1;
        end else begin
            match_nx = MATCH_W'(1);
        end
        snap_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (snap_q[i]) snap_idx = 4'(i);
        end
    end

    // Debounce: stable state follows a snapshot seen DEBOUNCE_SCANS times in a row.
    // A press fires only on the released -> exactly-one-key transition.
    always_ff @(posedge clk or posedge reseta) begin
        if (reseta) begin
            prev_q      <= '0;
            stable_q    <= '0;
            match_q     <= '0;
            press_q     <= 1'b0;
            press_idx_q <= '0;
        end else begin
            press_q <= 1'b0;
            if (snap_valid_q) begin
                prev_q  <= snap_q;
                match_q <= match_nx;
                if (match_nx == MATCH_MAX) begin
                    stable_q <= snap_q;
                    if (stable_q == '0 && $onehot(snap_q)) begin
                        press_q     <= 1'b1;
                        press_idx_q <= snap_idx;
                    end
                end
            end
        end
    end

    // Decimal value of the four BCD digits.
    always_comb begin
        code     = KEY_MAP[press_idx_q];
        tempo_nx = 16'(digits_q[15:12]) * 16'd1000 + 16'(digits_q[11:8]) * 16'd100
                 + 16'(digits_q[7:4]) * 16'd10 + 16'(digits_q[3:0]);
    end

    // Digit store and registered outputs; tempo trails the digits by one cycle.
    always_ff @(posedge clk or posedge reseta) begin
        if (reseta) begin
            digits_q    <= '0;
            tempo_q     <= '0;
            key_valid_q <= 1'b0;
            salve_q     <= 1'b0;
            key_code_q  <= '0;
        end else begin
            key_valid_q <= press_q;
            salve_q     <= press_q && (code == 4'hF);
            tempo_q     <= tempo_nx;
            if (press_q) begin
                key_code_q <= code;
                if (kp.cfg) begin
                    if (code <= 4'd9) begin
                        // Full entry: further digits are dropped rather than wrapping.
                        if (digits_q[15:12] == 4'd0) digits_q <= {digits_q[11:0], code};
                    end else if (code == 4'hA) begin
                        digits_q <= {4'h0, digits_q[15:4]};
                    end else if (code == 4'hE) begin
                        digits_q <= '0;
                    end
                end
            end
        end
    end

    assign kp.col       = col_q;
    assign kp.tempo     = tempo_q;
    assign kp.salve     = salve_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Directed bench for keypad_bcd_entry with a behavioural 4x4 keypad matrix.
module tb_keypad_bcd_entry;

    logic        clk = 1'b0;
    logic        reseta;
    logic [15:0] pressed;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          kv_cnt = 0;
    int          salve_cnt = 0;
    int          salve_lone = 0;
    logic [3:0]  last_code = 4'h0;
    int          kv_base;

    keypad_bcd_entry_if kp();

    keypad_bcd_entry #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk    (clk),
        .reseta (reseta),
        .kp     (kp)
    );

    always #5 clk = ~clk;

    // Matrix model: a row reads low when a pressed key sits on a column driven low.
    function automatic logic [3:0] row_model(input logic [15:0] p, input logic [3:0] c);
        logic [3:0] r_out;
        r_out = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                if (!c[k] && p[r*4+k]) r_out[r] = 1'b0;
            end
        end
        return r_out;
    endfunction

    assign kp.row = row_model(pressed, kp.col);

    // Event monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (kp.key_valid) begin
            kv_cnt    <= kv_cnt + 1;
            last_code <= kp.key_code;
        end
        if (kp.salve) begin
            salve_cnt <= salve_cnt + 1;
            if (!kp.key_valid) salve_lone <= salve_lone + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_scans(input int n);
        repeat (n * 16) @(posedge clk);
        #1;
    endtask

    task automatic tap(input int idx);
        pressed = 16'(1) << idx;
        wait_scans(10);
        pressed = '0;
        wait_scans(10);
    endtask

    initial begin
        pressed = '0;
        kp.cfg  = 1'b0;
        reseta  = 1'b1;
        #1;
        check("rst_col",   32'(kp.col), 32'hE);
        check("rst_tempo", 32'(kp.tempo), 32'd0);
        check("rst_salve", 32'(kp.salve), 32'd0);
        check("rst_kv",    32'(kp.key_valid), 32'd0);
        check("rst_code",  32'(kp.key_code), 32'd0);
        repeat (3) @(posedge clk);
        #2 reseta = 1'b0;
        wait_scans(4);
        check("idle_kv", 32'(kv_cnt), 32'd0);

        // Digit entry 1,2,3,4.
        kp.cfg = 1'b1;
        tap(0);  check("t_1", 32'(kp.tempo), 32'd1);
        check("code_1", 32'(last_code), 32'h1);
        tap(1);  check("t_12", 32'(kp.tempo), 32'd12);
        tap(2);  check("t_123", 32'(kp.tempo), 32'd123);
        tap(4);  check("t_1234", 32'(kp.tempo), 32'h04D2);
        check("kv_4", 32'(kv_cnt), 32'd4);

        // Full entry, backspace, clear, refill to 9999.
        tap(5);  check("t_full", 32'(kp.tempo), 32'd1234);
        check("code_5", 32'(last_code), 32'h5);
        tap(3);  check("t_bksp", 32'(kp.tempo), 32'd123);
        check("code_a", 32'(last_code), 32'hA);
        tap(12); check("t_clr", 32'(kp.tempo), 32'd0);
        check("code_star", 32'(last_code), 32'hE);
        tap(10); tap(10); tap(10); tap(10);
        check("t_9999", 32'(kp.tempo), 32'd9999);
        check("kv_11", 32'(kv_cnt), 32'd11);

        // '#' in both modes.
        kp.cfg = 1'b0;
        tap(14);
        check("salve_c0", 32'(salve_cnt), 32'd1);
        check("code_hash0", 32'(last_code), 32'hF);
        check("t_hash0", 32'(kp.tempo), 32'd9999);
        kp.cfg = 1'b1;
        tap(14);
        check("salve_c1", 32'(salve_cnt), 32'd2);
        check("code_hash1", 32'(last_code), 32'hF);
        check("t_hash1", 32'(kp.tempo), 32'd9999);
        check("salve_lone", 32'(salve_lone), 32'd0);
        tap(12); check("t_clr2", 32'(kp.tempo), 32'd0);

        // Bouncing '7', then multi-key holds.
        kv_base = kv_cnt;
        pressed = 16'(1) << 8; wait_scans(1);
        pressed = '0;          wait_scans(1);
        pressed = 16'(1) << 8; wait_scans(10);
        check("bounce_kv", 32'(kv_cnt - kv_base), 32'd1);
        check("code_7", 32'(last_code), 32'h7);
        check("t_7", 32'(kp.tempo), 32'd7);
        pressed = pressed | (16'(1) << 9); wait_scans(10);
        check("two_keys_kv", 32'(kv_cnt - kv_base), 32'd1);
        pressed = 16'(1) << 9; wait_scans(10);
        check("rel_one_kv", 32'(kv_cnt - kv_base), 32'd1);
        pressed = '0; wait_scans(10);
        tap(9);
        check("kv_8", 32'(kv_cnt - kv_base), 32'd2);
        check("code_8", 32'(last_code), 32'h8);
        check("t_78", 32'(kp.tempo), 32'd78);

        // Counting mode ignores digit and clear keys.
        kp.cfg = 1'b0;
        kv_base = kv_cnt;
        tap(5);
        check("c0_code5", 32'(last_code), 32'h5);
        check("c0_t5", 32'(kp.tempo), 32'd78);
        tap(12);
        check("c0_codestar", 32'(last_code), 32'hE);
        check("c0_tstar", 32'(kp.tempo), 32'd78);
        check("c0_kv", 32'(kv_cnt - kv_base), 32'd2);

        // Reset mid-scan with '5' held.
        kp.cfg  = 1'b1;
        kv_base = kv_cnt;
        pressed = 16'(1) << 5;
        repeat (7) @(posedge clk);
        #3 reseta = 1'b1;
        #1;
        check("mrst_col",   32'(kp.col), 32'hE);
        check("mrst_tempo", 32'(kp.tempo), 32'd0);
        check("mrst_salve", 32'(kp.salve), 32'd0);
        check("mrst_kv",    32'(kp.key_valid), 32'd0);
        check("mrst_code",  32'(kp.key_code), 32'd0);
        repeat (3) @(posedge clk);
        #2 reseta = 1'b0;
        wait_scans(10);
        check("mrst_ev", 32'(kv_cnt - kv_base), 32'd1);
        check("mrst_code5", 32'(last_code), 32'h5);
        check("mrst_t5", 32'(kp.tempo), 32'd5);
        pressed = '0;
        wait_scans(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
